// File: rtl/drum_timing_gen_if.sv
// Seek handshake bundle for drum_timing_gen: request/address in, ready/hit/error out.
interface drum_timing_gen_if #(
  parameter int ADDR_BITS = 7
) ();
  logic                 seek_req;
  logic [ADDR_BITS-1:0] seek_addr;
  logic                 seek_ready;
  logic                 seek_hit;
  logic                 seek_err;

  modport master (output seek_req, output seek_addr,
                  input seek_ready, input seek_hit, input seek_err);
  modport slave  (input seek_req, input seek_addr,
                  output seek_ready, output seek_hit, output seek_err);
endinterface

// File: rtl/drum_timing_gen.sv
// Drum timing track generator (Z1 bit clock, Z2 word marks, Z3 serial sector address).
// Optional sector seek unit compiled in when DRUM_SEEK_EN is defined.
module drum_timing_gen #(
  parameter int WORD_BITS = 40,
  parameter int WORDS     = 128,
  parameter int ADDR_BITS = 7,
  parameter int CLK_DIV   = 10,
  parameter int PULSE_W   = 2
) (
  input  logic                         CLK,
  input  logic                         CLR,
  output logic                         Z1,
  output logic                         _Z1,
  output logic                         Z2,
  output logic                         _Z2,
  output logic                         Z3,
  output logic                         _Z3,
  output logic [$clog2(WORD_BITS)-1:0] bit_idx,
  output logic [ADDR_BITS-1:0]         word_idx,
  output logic                         index,
  drum_timing_gen_if.slave             seek
);
  localparam int BW  = $clog2(WORD_BITS);
  localparam int PHW = $clog2(CLK_DIV);
  localparam logic [PHW-1:0]       PH_MAX   = PHW'(CLK_DIV - 1);
  localparam logic [PHW-1:0]       PW_C     = PHW'(PULSE_W);
  localparam logic [BW-1:0]        BIT_MAX  = BW'(WORD_BITS - 1);
  localparam logic [BW-1:0]        Z2A_LO   = BW'(WORD_BITS - 9);
  localparam logic [BW-1:0]        Z2A_HI   = BW'(WORD_BITS - 7);
  localparam logic [BW-1:0]        Z2B_LO   = BW'(WORD_BITS - 2);
  localparam logic [BW-1:0]        Z3_LO    = BW'(WORD_BITS - 1 - ADDR_BITS);
  localparam logic [BW-1:0]        Z3_HI    = BW'(WORD_BITS - 2);
  localparam logic [ADDR_BITS-1:0] WORD_MAX = ADDR_BITS'(WORDS - 1);

  logic [PHW-1:0]       phase_q, phase_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [ADDR_BITS-1:0] word_q, word_d;
  logic                 z1_q, z2_q, z3_q, nz1_q, nz2_q, nz3_q, index_q;
  logic                 z1_d, z2_d, z3_d, index_d;
  logic                 phase_wrap, bit_wrap, word_start_d;
  logic [ADDR_BITS-1:0] nxt_addr, nxt_sh;
  logic [BW-1:0]        z3_off;

  // Outputs are derived from the next counter values so they line up with the counters.
  always_comb begin
    phase_wrap   = (phase_q == PH_MAX);
    bit_wrap     = (bit_q == BIT_MAX);
    phase_d      = phase_wrap ? '0 : phase_q + 1'b1;
    bit_d        = bit_q;
    word_d       = word_q;
    if (phase_wrap) begin
      bit_d = bit_wrap ? '0 : bit_q + 1'b1;
      if (bit_wrap) word_d = (word_q == WORD_MAX) ? '0 : word_q + 1'b1;
    end
    word_start_d = (phase_d == '0) && (bit_d == '0);
    index_d      = word_start_d && (word_d == '0);
    z1_d         = (phase_d < PW_C);
    z2_d         = ((bit_d >= Z2A_LO) && (bit_d <= Z2A_HI)) || (bit_d >= Z2B_LO);
    nxt_addr     = (word_d == WORD_MAX) ? '0 : word_d + 1'b1;
    z3_off       = bit_d - Z3_LO;
    nxt_sh       = nxt_addr >> z3_off;
    z3_d         = 1'b0;
    if ((bit_d >= Z3_LO) && (bit_d <= Z3_HI)) z3_d = nxt_sh[0];
    else if (bit_d == BIT_MAX)                z3_d = (nxt_addr == '0);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      phase_q <= PH_MAX;
      bit_q   <= BIT_MAX;
      word_q  <= WORD_MAX;
      z1_q    <= 1'b0;
      z2_q    <= 1'b0;
      z3_q    <= 1'b0;
      nz1_q   <= 1'b1;
      nz2_q   <= 1'b1;
      nz3_q   <= 1'b1;
      index_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      z1_q    <= z1_d;
      z2_q    <= z2_d;
      z3_q    <= z3_d;
      nz1_q   <= ~z1_d;
      nz2_q   <= ~z2_d;
      nz3_q   <= ~z3_d;
      index_q <= index_d;
    end
  end

  assign Z1       = z1_q;
  assign _Z1      = nz1_q;
  assign Z2       = z2_q;
  assign _Z2      = nz2_q;
  assign Z3       = z3_q;
  assign _Z3      = nz3_q;
  assign bit_idx  = bit_q;
  assign word_idx = word_q;
  assign index    = index_q;

`ifdef DRUM_SEEK_EN
  localparam int CW = ADDR_BITS + 1;
  localparam logic [CW-1:0] WORDS_C = CW'(WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} seek_state_e;

  seek_state_e          state_q, state_d;
  logic [ADDR_BITS-1:0] tgt_q, tgt_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ready_q, hit_q, err_q;
  logic                 ready_d, hit_d, err_d;

  // cnt counts word starts seen without a match; reaching WORDS means the target is unreachable.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (seek.seek_req) begin
          tgt_d   = seek.seek_addr;
          cnt_d   = '0;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (word_start_d) begin
          if (word_d == tgt_q) begin
            hit_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == WORDS_C) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
    end
  end

  assign seek.seek_ready = ready_q;
  assign seek.seek_hit   = hit_q;
  assign seek.seek_err   = err_q;
`else
  logic unused_seek;
  assign unused_seek     = ^{seek.seek_req, seek.seek_addr};
  assign seek.seek_ready = 1'b1;
  assign seek.seek_hit   = 1'b0;
  assign seek.seek_err   = 1'b0;
`endif
endmodule

// File: tb/tb_drum_timing_gen.sv
// Bench for drum_timing_gen: arithmetic track model plus seek scoreboard on a small instance,
// and a default-parameter instance checked over one full revolution.
module tb_drum_timing_gen;
  localparam int S_WB = 24, S_WORDS = 12, S_AB = 4, S_CD = 4, S_PW = 1;
  localparam int S_WLEN = S_CD * S_WB, S_REV = S_WLEN * S_WORDS;
  localparam int D_WB = 40, D_WORDS = 128, D_AB = 7, D_CD = 10, D_PW = 2;

  logic CLK = 1'b0;
  logic clr_s, clr_d;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int s_cyc  = 0;
  int d_cyc  = 0;
  int last_evt = 0;

  typedef struct {int acc; int evt; bit is_err;} seek_t;
  seek_t sq[$];

  logic s_z1, s_nz1, s_z2, s_nz2, s_z3, s_nz3, s_index;
  logic [$clog2(S_WB)-1:0] s_bit;
  logic [S_AB-1:0]         s_word;
  logic d_z1, d_nz1, d_z2, d_nz2, d_z3, d_nz3, d_index;
  logic [$clog2(D_WB)-1:0] d_bit;
  logic [D_AB-1:0]         d_word;

  drum_timing_gen_if #(.ADDR_BITS(S_AB)) s_if ();
  drum_timing_gen_if #(.ADDR_BITS(D_AB)) d_if ();

  drum_timing_gen #(.WORD_BITS(S_WB), .WORDS(S_WORDS), .ADDR_BITS(S_AB), .CLK_DIV(S_CD), .PULSE_W(S_PW)) u_small (
    .CLK(CLK), .CLR(clr_s), .Z1(s_z1), ._Z1(s_nz1), .Z2(s_z2), ._Z2(s_nz2), .Z3(s_z3), ._Z3(s_nz3),
    .bit_idx(s_bit), .word_idx(s_word), .index(s_index), .seek(s_if));

  drum_timing_gen #(.WORD_BITS(D_WB), .WORDS(D_WORDS), .ADDR_BITS(D_AB), .CLK_DIV(D_CD), .PULSE_W(D_PW)) u_def (
    .CLK(CLK), .CLR(clr_d), .Z1(d_z1), ._Z1(d_nz1), .Z2(d_z2), ._Z2(d_nz2), .Z3(d_z3), ._Z3(d_nz3),
    .bit_idx(d_bit), .word_idx(d_word), .index(d_index), .seek(d_if));

  always @(posedge CLK or negedge clr_s) if (!clr_s) s_cyc <= 0; else s_cyc <= s_cyc + 1;
  always @(posedge CLK or negedge clr_d) if (!clr_d) d_cyc <= 0; else d_cyc <= d_cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Track contents at t edges after reset release; order {Z1,_Z1,Z2,_Z2,Z3,_Z3,index}.
  function automatic void model(input int t, input int cd, input int pw, input int wb, input int words,
                                input int ab, output logic [6:0] sig, output int b, output int w);
    int p, ph, nxt;
    logic z1, z2, z3, ix;
    if (t == 0) begin
      sig = 7'b0101010; b = wb - 1; w = words - 1;
      return;
    end
    p   = (t - 1) % (cd * wb * words);
    ph  = p % cd;
    b   = (p / cd) % wb;
    w   = p / (cd * wb);
    z1  = (ph < pw);
    z2  = ((b >= wb - 9) && (b <= wb - 7)) || (b >= wb - 2);
    nxt = (w + 1) % words;
    z3  = 1'b0;
    if ((b >= wb - 1 - ab) && (b <= wb - 2)) z3 = ((nxt >> (b - (wb - 1 - ab))) & 1) != 0;
    else if (b == wb - 1)                    z3 = (nxt == 0);
    ix  = (p == 0);
    sig = {z1, !z1, z2, !z2, z3, !z3, ix};
  endfunction

  // Walk word starts after acceptance edge a: first matching start hits, the WORDS-th start errors.
  function automatic void predict(input int a, input int tgt, output int evt, output bit er);
    int n = 0;
    evt = -1; er = 1'b0;
    for (int e = a + 1; e <= a + S_REV + S_WLEN; e++) begin
      if ((e - 1) % S_WLEN == 0) begin
        n++;
        if (((e - 1) / S_WLEN) % S_WORDS == tgt) begin evt = e; er = 1'b0; return; end
        if (n == S_WORDS) begin evt = e; er = 1'b1; return; end
      end
    end
  endfunction

  always @(negedge CLK) begin
    logic [6:0] es;
    int eb, ew;
    logic exp_rdy;
    seek_t e;
    model(s_cyc, S_CD, S_PW, S_WB, S_WORDS, S_AB, es, eb, ew);
    chk("s_tracks", {25'd0, s_z1, s_nz1, s_z2, s_nz2, s_z3, s_nz3, s_index}, {25'd0, es});
    chk("s_bit_idx", 32'(s_bit), eb);
    chk("s_word_idx", 32'(s_word), ew);
    exp_rdy = !(sq.size() > 0 && s_cyc >= sq[0].acc && s_cyc <= sq[0].evt);
    chk("seek_ready", 32'(s_if.seek_ready), 32'(exp_rdy));
    if (s_if.seek_hit || s_if.seek_err) begin
      if (sq.size() == 0) chk("seek_spurious", {30'd0, s_if.seek_hit, s_if.seek_err}, 32'd0);
      else begin
        e = sq.pop_front();
        chk("seek_cycle", s_cyc, e.evt);
        chk("seek_kind", {30'd0, s_if.seek_hit, s_if.seek_err}, e.is_err ? 32'd1 : 32'd2);
      end
    end else if (sq.size() > 0 && s_cyc > sq[0].evt) begin
      e = sq.pop_front();
      chk("seek_missed", s_cyc, e.evt);
    end
  end

  always @(negedge CLK) begin
    logic [6:0] es;
    int eb, ew;
    model(d_cyc, D_CD, D_PW, D_WB, D_WORDS, D_AB, es, eb, ew);
    chk("d_tracks", {25'd0, d_z1, d_nz1, d_z2, d_nz2, d_z3, d_nz3, d_index}, {25'd0, es});
    chk("d_bit_idx", 32'(d_bit), eb);
    chk("d_word_idx", 32'(d_word), ew);
  end

  task automatic wait_idle();
    for (int g = 0; s_cyc <= last_evt; g++) begin
      if (g > 4 * S_REV) begin
        chk("idle_timeout", s_cyc, last_evt + 1);
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic issue(input int tgt, input int hold);
    int evt;
    bit er;
    wait_idle();
    s_if.seek_req  = 1'b1;
    s_if.seek_addr = S_AB'(tgt);
`ifdef DRUM_SEEK_EN
    predict(s_cyc + 1, tgt, evt, er);
    sq.push_back('{s_cyc + 1, evt, er});
    last_evt = evt;
`else
    last_evt = s_cyc;
`endif
    repeat (hold) @(negedge CLK);
    s_if.seek_req  = 1'b0;
    s_if.seek_addr = S_AB'($urandom_range(0, 15));
  endtask

  initial begin
    clr_s = 1'b0; clr_d = 1'b0;
    s_if.seek_req = 1'b0; s_if.seek_addr = '0;
    d_if.seek_req = 1'b0; d_if.seek_addr = '0;
    repeat (3) @(negedge CLK);
    #1 clr_s = 1'b1; clr_d = 1'b1;
    @(negedge CLK);

    // Target equals the word starting on the acceptance edge: hits one revolution later.
    wait_idle();
    for (int k = 0; k < S_WLEN + 2 && (s_cyc % S_WLEN) != 0; k++) @(negedge CLK);
    issue((s_cyc / S_WLEN) % S_WORDS, 1);
    issue(15, 2);
    issue(10, 1);
    for (int i = 0; i < 14; i++) begin
      repeat ($urandom_range(0, 40)) @(negedge CLK);
      issue($urandom_range(0, 15), $urandom_range(1, 3));
    end

    // Reset in the middle of an armed seek: no pulse may follow.
    issue(14, 1);
    repeat (20) @(negedge CLK);
    #1 clr_s = 1'b0;
    sq.delete();
    last_evt = 0;
    repeat (5) @(negedge CLK);
    #1 clr_s = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge CLK);
      issue($urandom_range(0, 15), 1);
    end

`ifndef DRUM_SEEK_EN
    s_if.seek_req = 1'b1;
    repeat (300) @(negedge CLK);
    s_if.seek_req = 1'b0;
`endif

    wait_idle();
    repeat (3) @(negedge CLK);
    for (int g = 0; d_cyc < 51210 && g < 60000; g++) @(negedge CLK);
    chk("seek_queue_empty", sq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
